// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 raster constants and width helper functions
//            shared by the VGA timing generator and its axis counters.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    // Vertical timing, in lines
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Register width able to hold 0..modulus-1, never narrower than one bit
    function automatic int cnt_width(input int modulus);
        int w;
        w = clog2(modulus);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : Modulo-N up counter with count enable and a terminal-count flag.
//            Used for the pixel-clock divider and both raster axes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    if (MODULUS < 1) begin : g_bad_modulus
        $error("vga_axis_counter: MODULUS must be at least 1");
    end

    if (WIDTH < cnt_width(MODULUS)) begin : g_bad_width
        $error("vga_axis_counter: WIDTH too small for MODULUS");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_tc;

    assign w_tc = (count_q == c_last);

    // Next count: advance when enabled, wrap to zero after the last value
    always_comb begin
        count_d = count_q;
        if (i_en) begin
            count_d = w_tc ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = w_tc;

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_generator
// Brief    : Parametrised VGA raster generator. Divides the system clock into
//            a pixel tick, generates HSync/VSync with configurable porches and
//            polarity, and fetches pixels for a framebuffer window. Colour,
//            sync and blanking leave the block aligned one tick after the
//            counters, matching the one-tick memory read latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int WIN_X0   = 192,
    parameter int WIN_Y0   = 112,
    parameter int WIN_W    = 256,
    parameter int WIN_H    = 256,
    parameter int COLOR_W  = 1,
    parameter int ADDR_W   = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iEnable,
    input  logic [3*COLOR_W-1:0]   iBorderColor,
    output logic [ADDR_W-1:0]      oReadAddress,
    input  logic [3*COLOR_W-1:0]   wColorFromVideoMemory,
    output logic [COLOR_W-1:0]     oVGA_Red,
    output logic [COLOR_W-1:0]     oVGA_Green,
    output logic [COLOR_W-1:0]     oVGA_Blue,
    output logic                   oHSync,
    output logic                   oVSync,
    output logic                   oDisplayEnable,
    output logic                   oFrameStart
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw    = cnt_width(c_h_tot);
    localparam int c_vw    = cnt_width(c_v_tot);
    localparam int c_dw    = cnt_width(CLK_DIV);

    // Window edges clipped to the active area so out-of-range parameters
    // can never address beyond the framebuffer
    localparam int c_wx0_i = (WIN_X0 > H_ACTIVE) ? H_ACTIVE : WIN_X0;
    localparam int c_wy0_i = (WIN_Y0 > V_ACTIVE) ? V_ACTIVE : WIN_Y0;
    localparam int c_wx1_i = (WIN_X0 + WIN_W > H_ACTIVE) ? H_ACTIVE : WIN_X0 + WIN_W;
    localparam int c_wy1_i = (WIN_Y0 + WIN_H > V_ACTIVE) ? V_ACTIVE : WIN_Y0 + WIN_H;

    localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_beg  = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end  = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_hw-1:0] c_wx0     = c_hw'(c_wx0_i);
    localparam logic [c_hw-1:0] c_wx1     = c_hw'(c_wx1_i);
    localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_beg  = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end  = c_vw'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_vw-1:0] c_wy0     = c_vw'(c_wy0_i);
    localparam logic [c_vw-1:0] c_wy1     = c_vw'(c_wy1_i);
    localparam logic [ADDR_W-1:0] c_win_w = ADDR_W'(WIN_W);

    localparam logic c_hs_on = (HS_POL != 0);
    localparam logic c_vs_on = (VS_POL != 0);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_generator: CLK_DIV must be at least 1");
    end

    if (WIN_X0 + WIN_W > H_ACTIVE) begin : g_win_x_overflow
        $error("vga_timing_generator: window extends beyond active width");
    end

    if (WIN_Y0 + WIN_H > V_ACTIVE) begin : g_win_y_overflow
        $error("vga_timing_generator: window extends beyond active height");
    end

    if (clog2(WIN_W * WIN_H) > ADDR_W) begin : g_addr_too_narrow
        $error("vga_timing_generator: ADDR_W too small for window size");
    end

    // ------------------------------------------------------------------------
    // Pixel tick and raster counters
    // ------------------------------------------------------------------------
    logic [c_dw-1:0] w_div_count;
    logic            w_div_tc;
    logic [c_hw-1:0] w_hcount;
    logic            w_h_tc;
    logic [c_vw-1:0] w_vcount;
    logic            w_v_tc;
    logic            w_tick;
    logic            w_unused;

    assign w_tick = iEnable & w_div_tc;

    vga_axis_counter #(
        .MODULUS (CLK_DIV),
        .WIDTH   (c_dw)
    ) u_div (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_en    (iEnable),
        .o_count (w_div_count),
        .o_tc    (w_div_tc)
    );

    vga_axis_counter #(
        .MODULUS (c_h_tot),
        .WIDTH   (c_hw)
    ) u_hcount (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_en    (w_tick),
        .o_count (w_hcount),
        .o_tc    (w_h_tc)
    );

    vga_axis_counter #(
        .MODULUS (c_v_tot),
        .WIDTH   (c_vw)
    ) u_vcount (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_en    (w_tick & w_h_tc),
        .o_count (w_vcount),
        .o_tc    (w_v_tc)
    );

    // Divider count and last-line flag are only needed inside the counters
    assign w_unused = ^{w_div_count, w_v_tc};

    // ------------------------------------------------------------------------
    // Stage 0: decode current counter position and form the read address
    // ------------------------------------------------------------------------
    logic              w_active;
    logic              w_hs_region;
    logic              w_vs_region;
    logic              w_in_win;
    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_col_off;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign w_active    = (w_hcount < c_h_act) && (w_vcount < c_v_act);
    assign w_hs_region = (w_hcount >= c_hs_beg) && (w_hcount < c_hs_end);
    assign w_vs_region = (w_vcount >= c_vs_beg) && (w_vcount < c_vs_end);
    assign w_in_win    = w_active
                       && (w_hcount >= c_wx0) && (w_hcount < c_wx1)
                       && (w_vcount >= c_wy0) && (w_vcount < c_wy1);

    assign w_row_off = ADDR_W'(w_vcount - c_wy0);
    assign w_col_off = ADDR_W'(w_hcount - c_wx0);
    assign w_addr    = (w_row_off * c_win_w) + w_col_off;

    // Outside the window the last fetched address is presented unchanged
    always_comb begin
        addr_d = addr_q;
        if (w_in_win) begin
            addr_d = w_addr;
        end
    end

    // Hold register for the read address
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign oReadAddress = addr_d;

    // ------------------------------------------------------------------------
    // Stage 1: timing flags delayed one tick to meet the memory read data
    // ------------------------------------------------------------------------
    logic hsync_q,       hsync_d;
    logic vsync_q,       vsync_d;
    logic active_q,      active_d;
    logic in_win_q,      in_win_d;
    logic frame_start_q, frame_start_d;

    // Capture stage-0 flags on each pixel tick; frame start is a single clock
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        in_win_d      = in_win_q;
        frame_start_d = 1'b0;
        if (w_tick) begin
            hsync_d       = w_hs_region ? c_hs_on : ~c_hs_on;
            vsync_d       = w_vs_region ? c_vs_on : ~c_vs_on;
            active_d      = w_active;
            in_win_d      = w_in_win;
            frame_start_d = (w_hcount == '0) && (w_vcount == '0);
        end
    end

    // Stage-1 registers; reset drives syncs to their inactive level
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hsync_q       <= ~c_hs_on;
            vsync_q       <= ~c_vs_on;
            active_q      <= 1'b0;
            in_win_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            in_win_q      <= in_win_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output colour: memory data inside the window, border elsewhere in the
    // active area, black while blanking or paused
    // ------------------------------------------------------------------------
    logic [3*COLOR_W-1:0] w_color;

    // Colour select; memory data is already one tick late, matching stage 1
    always_comb begin
        w_color = '0;
        if (iEnable) begin
            if (in_win_q) begin
                w_color = wColorFromVideoMemory;
            end else if (active_q) begin
                w_color = iBorderColor;
            end
        end
    end

    assign oVGA_Red       = w_color[3*COLOR_W-1:2*COLOR_W];
    assign oVGA_Green     = w_color[2*COLOR_W-1:COLOR_W];
    assign oVGA_Blue      = w_color[COLOR_W-1:0];
    assign oHSync         = hsync_q;
    assign oVSync         = vsync_q;
    assign oDisplayEnable = active_q & iEnable;
    assign oFrameStart    = frame_start_q;

endmodule : vga_timing_generator
`default_nettype wire

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA raster generator: derives the pixel tick from the system clock, produces HSync/VSync with configurable porches and polarity, and fetches pixels for a rectangular framebuffer window placed anywhere on screen. It sits between the video memory read port and the VGA pins, replacing the fixed 640x480, 1-bit-per-channel controller. Memory read latency is pipelined so that colour, sync and blanking leave the block aligned.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porches and sync width (lines)
- HS_POL, 0 / VS_POL, 0: active level of oHSync / oVSync
- CLK_DIV, 2: system clocks per pixel tick (≥1)
- WIN_X0, 192 / WIN_Y0, 112 / WIN_W, 256 / WIN_H, 256: framebuffer window origin and size in active-area pixels
- COLOR_W, 1: bits per colour channel
- ADDR_W, 16: read address width; must satisfy 2^ADDR_W ≥ WIN_W*WIN_H
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- iEnable  in  1  1 = run; 0 = hold counters, drive blanking
- iBorderColor  in  3*COLOR_W  colour for active pixels outside the window
- oReadAddress  out  ADDR_W  video memory read address
- wColorFromVideoMemory  in  3*COLOR_W  {R,G,B} read data, valid one pixel tick after address
- oVGA_Red / oVGA_Green / oVGA_Blue  out  COLOR_W each  pixel colour
- oHSync / oVSync  out  1  sync pulses, polarity per HS_POL/VS_POL
- oDisplayEnable  out  1  1 while an active-area pixel is on the colour outputs
- oFrameStart  out  1  one-system-clock pulse when pixel (0,0) is presented

## Operation
- Divider counts 0..CLK_DIV-1; pixel tick = terminal count while iEnable=1. CLK_DIV=1: tick every clock.
- hcount 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; advances on tick, wraps to 0 and increments vcount.
- vcount 0..V_TOTAL-1, wraps to 0 after V_TOTAL-1 on the same tick hcount wraps.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical identical in lines.
- Stage 0 (current counts): in_win = active && WIN_X0≤h<WIN_X0+WIN_W && WIN_Y0≤v<WIN_Y0+WIN_H; oReadAddress = (v-WIN_Y0)*WIN_W + (h-WIN_X0) when in_win, else held.
- Stage 1 (registered on tick): sync, active, in_win delayed one tick; colour = memory data if in_win, iBorderColor if active outside window, 0 when blanking.
- Address arithmetic in ADDR_W bits, no overflow given parameter constraint; window clipped to active area at elaboration (assertion if WIN_X0+WIN_W>H_ACTIVE or WIN_Y0+WIN_H>V_ACTIVE).
- iEnable=0: divider and counters freeze; colour outputs 0, oDisplayEnable 0, syncs keep last value. Resuming continues from frozen position.

## Timing
- Reset values: counters 0, oReadAddress 0, colours 0, oDisplayEnable 0, oFrameStart 0, oHSync=~HS_POL, oVSync=~VS_POL.
- First tick after reset release: CLK_DIV clocks later. Outputs for pixel (h,v) appear one pixel tick after counters equal (h,v); fixed pipeline latency 1 tick.
- Sync, enable and colour change on the same system clock edge.
- oFrameStart high for exactly one clock at the edge pixel (0,0) reaches stage 1.
- Reset assertion mid-frame: all outputs return to reset values immediately (asynchronously); restart at (0,0).

## Structure
- Package vga_timing_pkg: default 640x480@60 constants (H/V active, porches, sync widths, totals) and a clog2 function for ADDR_W checks.
- Sub-module vga_axis_counter (modulus and enable parameterised, terminal-count output), instantiated for divider, hcount, vcount.

## Test plan
- Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1), release reset -> oHSync low exactly 2 ticks starting at tick 11 (10 + latency), line period 14 ticks, frame 98 ticks.
- Window X0=2,Y0=1,W=4,H=2, memory returns address as colour -> pixel (3,2) shows data for address 5; pixels (0..1,1) show iBorderColor.
- CLK_DIV=3 -> every output holds 3 clocks; oFrameStart width 1 clock, period 3*H_TOTAL*V_TOTAL clocks.
- HS_POL=1, VS_POL=1 -> syncs idle low, pulse high; reset values low.
- iEnable dropped mid-line at h=5 for 10 clocks -> colours 0, DE 0, counters resume at h=5.
- Reset asserted during vsync -> oVSync goes inactive without a clock edge; next frame starts at (0,0).
